// File: rtl/bscac_seg_sched.sv
// Segment scheduler: accepts an NSEG-segment frame over valid/ready and
// issues it one segment per downstream beat with a rotating one-hot select.
// Optional statistics counters (frame_cnt, stall_cnt) are compiled in when
// the macro BSCAC_SCHED_STATS_EN is defined.
module bscac_seg_sched #(
    parameter int NSEG  = 3,
    parameter int SEG_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSEG*SEG_W-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SEG_W-1:0]        seg_data,
    output logic [NSEG-1:0]         seg_sel,
    output logic                    seg_valid,
    input  logic                    seg_ready,
    output logic                    seg_last,
    output logic                    busy
`ifdef BSCAC_SCHED_STATS_EN
    ,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             stall_cnt
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [NSEG-1:0] SEL0 = NSEG'(1);

    state_t                  state_q, state_d;
    logic [NSEG*SEG_W-1:0]   frame_q, frame_d;
    logic [SEG_W-1:0]        seg_data_d;
    logic [NSEG-1:0]         seg_sel_d;
    logic                    seg_valid_d;
    logic                    beat;
    logic                    last_beat;
    logic                    load;

    // Rotate the one-hot select left by one; degenerates to identity for NSEG=1.
    function automatic logic [NSEG-1:0] rotl(input logic [NSEG-1:0] s);
        logic [NSEG-1:0] r;
        r = '0;
        for (int k = 0; k < NSEG; k++) begin
            r[(k + 1) % NSEG] = s[k];
        end
        return r;
    endfunction

    // Mux the segment addressed by a one-hot select out of a frame.
    function automatic logic [SEG_W-1:0] pick(input logic [NSEG*SEG_W-1:0] f,
                                              input logic [NSEG-1:0]       s);
        logic [SEG_W-1:0] d;
        d = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (s[k]) d = d | f[k*SEG_W +: SEG_W];
        end
        return d;
    endfunction

    assign beat      = seg_valid & seg_ready;
    assign last_beat = beat & seg_sel[NSEG-1];
    assign seg_last  = seg_sel[NSEG-1] & seg_valid;
    // seg_ready feeds in_ready combinationally so a new frame can follow the
    // last segment with no bubble.
    assign in_ready  = !rst & ((state_q == IDLE) | last_beat);
    assign load      = in_valid & in_ready;
    assign busy      = (state_q == SEND);

    // Next-state and next-output decode; everything holds unless a load or beat occurs.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        seg_data_d  = seg_data;
        seg_sel_d   = seg_sel;
        seg_valid_d = seg_valid;
        if (load) begin
            frame_d     = in_data;
            seg_data_d  = in_data[SEG_W-1:0];
            seg_sel_d   = SEL0;
            seg_valid_d = 1'b1;
            state_d     = SEND;
        end else begin
            case (state_q)
                IDLE: begin
                    seg_valid_d = 1'b0;
                    seg_sel_d   = SEL0;
                end
                SEND: begin
                    if (last_beat) begin
                        seg_valid_d = 1'b0;
                        seg_sel_d   = SEL0;
                        state_d     = IDLE;
                    end else if (beat) begin
                        seg_sel_d  = rotl(seg_sel);
                        seg_data_d = pick(frame_q, rotl(seg_sel));
                    end
                end
                default: begin
                    seg_valid_d = 1'b0;
                    seg_sel_d   = SEL0;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partially issued frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            seg_data  <= '0;
            seg_sel   <= SEL0;
            seg_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            seg_data  <= seg_data_d;
            seg_sel   <= seg_sel_d;
            seg_valid <= seg_valid_d;
        end
    end

`ifdef BSCAC_SCHED_STATS_EN
    // Completed-frame counter (wraps) and stall-cycle counter (saturates).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (last_beat) frame_cnt <= frame_cnt + 16'd1;
            if (seg_valid && !seg_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bscac_seg_sched.sv
// Testbench for bscac_seg_sched: directed scenarios plus randomized traffic
// against a queue-based behavioural model; a second NSEG=1 instance is
// exercised for the degenerate case.
module tb_bscac_seg_sched;
    localparam int NSEG  = 3;
    localparam int SEG_W = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NSEG*SEG_W-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [SEG_W-1:0]      seg_data;
    logic [NSEG-1:0]       seg_sel;
    logic                  seg_valid;
    logic                  seg_ready;
    logic                  seg_last;
    logic                  busy;

    logic [SEG_W-1:0]      in_data1;
    logic                  in_valid1;
    logic                  in_ready1;
    logic [SEG_W-1:0]      seg_data1;
    logic [0:0]            seg_sel1;
    logic                  seg_valid1;
    logic                  seg_ready1;
    logic                  seg_last1;
    logic                  busy1;
`ifdef BSCAC_SCHED_STATS_EN
    logic [15:0] frame_cnt, stall_cnt, frame_cnt1, stall_cnt1;
`endif

    always #5 clk = ~clk;

    bscac_seg_sched #(.NSEG(NSEG), .SEG_W(SEG_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .seg_data(seg_data), .seg_sel(seg_sel),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_last(seg_last),
        .busy(busy)
`ifdef BSCAC_SCHED_STATS_EN
        , .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
`endif
    );

    bscac_seg_sched #(.NSEG(1), .SEG_W(SEG_W)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .seg_data(seg_data1), .seg_sel(seg_sel1),
        .seg_valid(seg_valid1), .seg_ready(seg_ready1), .seg_last(seg_last1),
        .busy(busy1)
`ifdef BSCAC_SCHED_STATS_EN
        , .frame_cnt(frame_cnt1), .stall_cnt(stall_cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of segments still owed downstream.
    typedef struct {
        logic [SEG_W-1:0] d;
        int               idx;
    } seg_t;
    seg_t q[$];
    logic en_model = 1'b0;

    always @(negedge clk) begin
        logic exp_ir;
        logic bt;
        seg_t s;
        if (en_model) begin
            if (q.size() == 0) begin
                chk("m_valid", 32'(seg_valid), 32'd0);
                chk("m_sel", 32'(seg_sel), 32'd1);
                chk("m_busy", 32'(busy), 32'd0);
                bt     = 1'b0;
                exp_ir = !rst;
            end else begin
                chk("m_valid", 32'(seg_valid), 32'd1);
                chk("m_data", 32'(seg_data), 32'(q[0].d));
                chk("m_sel", 32'(seg_sel), 32'd1 << q[0].idx);
                chk("m_last", 32'(seg_last), 32'(q[0].idx == NSEG - 1));
                chk("m_busy", 32'(busy), 32'd1);
                bt     = seg_ready;
                exp_ir = !rst && bt && (q[0].idx == NSEG - 1);
            end
            chk("m_in_ready", 32'(in_ready), 32'(exp_ir));
            if (rst) begin
                q.delete();
            end else begin
                if (bt) void'(q.pop_front());
                if (in_valid && exp_ir) begin
                    for (int k = 0; k < NSEG; k++) begin
                        s.d   = in_data[k*SEG_W +: SEG_W];
                        s.idx = k;
                        q.push_back(s);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [SEG_W-1:0] exp_d [3];
    logic [NSEG*SEG_W-1:0] fa, fb;
    logic [SEG_W-1:0] prev1;

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; seg_ready = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0; seg_ready1 = 1'b1;
        cyc(); cyc();
        chk("rst_valid", 32'(seg_valid), 32'd0);
        chk("rst_sel", 32'(seg_sel), 32'd1);
        chk("rst_data", 32'(seg_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        en_model = 1'b1;

        // Single frame with literal expectations
        cyc();
        in_data = {7'h55, 7'h2A, 7'h7F}; in_valid = 1'b1;
        #1 chk("sf_in_ready", 32'(in_ready), 32'd1);
        exp_d = '{7'h7F, 7'h2A, 7'h55};
        for (int c = 0; c < 3; c++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            chk("sf_valid", 32'(seg_valid), 32'd1);
            chk("sf_data", 32'(seg_data), 32'(exp_d[c]));
            chk("sf_sel", 32'(seg_sel), 32'd1 << c);
            chk("sf_last", 32'(seg_last), 32'(c == 2));
        end
        chk("sf_in_ready_last", 32'(in_ready), 32'd1);
        cyc(); #1;
        chk("sf_idle_valid", 32'(seg_valid), 32'd0);
        chk("sf_idle_sel", 32'(seg_sel), 32'd1);

        // Back-to-back frames with in_valid held high
        fa = 21'($urandom); fb = 21'($urandom);
        cyc();
        in_data = fa; in_valid = 1'b1;
        #1 chk("b2b_ir0", 32'(in_ready), 32'd1);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) in_data = fb;
            if (c == 4) in_valid = 1'b0;
            #1;
            chk("b2b_valid", 32'(seg_valid), 32'd1);
            chk("b2b_data", 32'(seg_data),
                c <= 3 ? 32'(fa[(c-1)*SEG_W +: SEG_W]) : 32'(fb[(c-4)*SEG_W +: SEG_W]));
            if (c <= 5) chk("b2b_in_ready", 32'(in_ready), 32'(c == 3));
        end
        cyc(); #1 chk("b2b_drain", 32'(seg_valid), 32'd0);

        // Backpressure on segment 1 for four cycles
        fa = 21'($urandom);
        cyc(); in_data = fa; in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        cyc(); seg_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cyc();
            #1;
            chk("bp_hold_data", 32'(seg_data), 32'(fa[SEG_W +: SEG_W]));
            chk("bp_hold_sel", 32'(seg_sel), 32'd2);
            chk("bp_hold_valid", 32'(seg_valid), 32'd1);
        end
        cyc(); seg_ready = 1'b1;
        #1 chk("bp_resume_sel", 32'(seg_sel), 32'd2);
        cyc(); #1;
        chk("bp_next_data", 32'(seg_data), 32'(fa[2*SEG_W +: SEG_W]));
        chk("bp_next_sel", 32'(seg_sel), 32'd4);
`ifdef BSCAC_SCHED_STATS_EN
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd4);
`endif
        cyc();

        // in_valid while busy mid-frame is ignored
        fa = 21'($urandom);
        cyc(); in_data = fa; in_valid = 1'b1;
        cyc(); in_data = ~fa;
        #1;
        chk("mid_in_ready1", 32'(in_ready), 32'd0);
        chk("mid_data0", 32'(seg_data), 32'(fa[SEG_W-1:0]));
        cyc(); #1;
        chk("mid_in_ready2", 32'(in_ready), 32'd0);
        chk("mid_data1", 32'(seg_data), 32'(fa[SEG_W +: SEG_W]));
        in_valid = 1'b0;
        cyc(); #1 chk("mid_data2", 32'(seg_data), 32'(fa[2*SEG_W +: SEG_W]));
        cyc(); #1 chk("mid_done", 32'(seg_valid), 32'd0);

        // Reset during segment 1
        fa = 21'($urandom);
        cyc(); in_data = fa; in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        cyc(); rst = 1'b1;
        #1 chk("rm_in_ready", 32'(in_ready), 32'd0);
        cyc(); #1;
        chk("rm_valid", 32'(seg_valid), 32'd0);
        chk("rm_sel", 32'(seg_sel), 32'd1);
        chk("rm_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc(); #1 chk("rm_no_resume", 32'(seg_valid), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            cyc();
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            seg_ready = ($urandom_range(0, 3) != 0);
            in_data   = 21'($urandom);
        end
        cyc(); rst = 1'b0; in_valid = 1'b0; seg_ready = 1'b1;
        repeat (5) cyc();

        // NSEG=1: every beat is last, a frame accepted every cycle
        prev1 = '0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            in_valid1 = 1'b1; seg_ready1 = 1'b1; in_data1 = 7'($urandom);
            #1;
            chk("n1_in_ready", 32'(in_ready1), 32'd1);
            if (c > 0) begin
                chk("n1_valid", 32'(seg_valid1), 32'd1);
                chk("n1_last", 32'(seg_last1), 32'd1);
                chk("n1_sel", 32'(seg_sel1), 32'd1);
                chk("n1_data", 32'(seg_data1), 32'(prev1));
            end
            prev1 = in_data1;
        end
        cyc(); in_valid1 = 1'b0;
        #1;
        chk("n1_tail_data", 32'(seg_data1), 32'(prev1));
        chk("n1_tail_last", 32'(seg_last1), 32'd1);
        cyc(); #1;
        chk("n1_idle_valid", 32'(seg_valid1), 32'd0);
        chk("n1_idle_sel", 32'(seg_sel1), 32'd1);

        en_model = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
